// File: rtl/video_timing_gen_pkg.sv
// 720x480 timing constants and the types shared by the video timing generator,
// its sync counters and the downstream video interface.
package VIDEO;

  localparam int unsigned COUNT_W = 10;

  localparam int unsigned H_ACTIVE_720 = 720;
  localparam int unsigned H_FP_720     = 16;
  localparam int unsigned H_SYNC_720   = 62;
  localparam int unsigned H_BP_720     = 60;
  localparam int unsigned H_TOTAL_720  = H_ACTIVE_720 + H_FP_720 + H_SYNC_720 + H_BP_720;

  localparam int unsigned V_ACTIVE_480 = 480;
  localparam int unsigned V_FP_480     = 9;
  localparam int unsigned V_SYNC_480   = 6;
  localparam int unsigned V_BP_480     = 30;
  localparam int unsigned V_TOTAL_480  = V_ACTIVE_480 + V_FP_480 + V_SYNC_480 + V_BP_480;

  typedef enum logic [1:0] {
    RESOLUTION_640_480   = 2'd0,
    RESOLUTION_720_480   = 2'd1,
    RESOLUTION_1280_720  = 2'd2,
    RESOLUTION_1920_1080 = 2'd3
  } resolution_e;

  typedef enum logic [1:0] {
    REGION_ACTIVE,
    REGION_FP,
    REGION_SYNC,
    REGION_BP
  } region_e;

  // Attributes of a pixel captured on its strobe, consumed one pixel later.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } pix_tag_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs_n;
    logic       vs_n;
  } video_out_t;

  localparam video_out_t VIDEO_OUT_IDLE = '{r: 8'h00, g: 8'h00, b: 8'h00, hs_n: 1'b1, vs_n: 1'b1};

  function automatic region_e region_of(input logic [COUNT_W-1:0] count,
                                        input int unsigned active,
                                        input int unsigned fp,
                                        input int unsigned sync);
    int unsigned c;
    c = 32'(count);
    if (c < active) return REGION_ACTIVE;
    if (c < active + fp) return REGION_FP;
    if (c < active + fp + sync) return REGION_SYNC;
    return REGION_BP;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Downstream parallel video bus: resolution code, colour, active-low syncs, pixel clock.
interface VIDEO_IF;

  VIDEO::resolution_e RESOLUTION;
  logic [7:0]         R;
  logic [7:0]         G;
  logic [7:0]         B;
  logic               HS_n;
  logic               VS_n;
  logic               DCLK;

  modport OUT (output RESOLUTION, R, G, B, HS_n, VS_n, DCLK);
  modport IN  (input  RESOLUTION, R, G, B, HS_n, VS_n, DCLK);

endinterface

// File: rtl/video_timing_gen_sync_counter.sv
// Generic wrapping line/pixel counter with active/porch/sync region decode;
// used once for horizontal and once for vertical timing.
module video_sync_counter
  import VIDEO::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_720,
  parameter int unsigned FP     = H_FP_720,
  parameter int unsigned SYNC   = H_SYNC_720,
  parameter int unsigned BP     = H_BP_720
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               adv_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               carry_o,
  output logic               active_o,
  output logic               sync_o
);

  localparam int unsigned        TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [COUNT_W-1:0] LAST  = COUNT_W'(TOTAL - 1);

  logic [COUNT_W-1:0] count_q, count_d;
  region_e            region;

  // NOTE: every variable gets its default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (adv_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + COUNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign region   = region_of(count_q, ACTIVE, FP, SYNC);
  assign count_o  = count_q;
  assign carry_o  = adv_i && (count_q == LAST);
  assign active_o = (region == REGION_ACTIVE);
  assign sync_o   = (region == REGION_SYNC);

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-rate timing generator: divides CLK into pixel strobes, scans X/Y, requests
// upstream colour and drives the video bus with a one-pixel output pipeline.
module video_timing_gen
  import VIDEO::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = H_ACTIVE_720,
  parameter int unsigned H_FP     = H_FP_720,
  parameter int unsigned H_SYNC   = H_SYNC_720,
  parameter int unsigned H_BP     = H_BP_720,
  parameter int unsigned V_ACTIVE = V_ACTIVE_480,
  parameter int unsigned V_FP     = V_FP_480,
  parameter int unsigned V_SYNC   = V_SYNC_480,
  parameter int unsigned V_BP     = V_BP_480
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  output logic               PIX_STB,
  output logic               PIX_REQ,
  output logic [COUNT_W-1:0] PIX_X,
  output logic [COUNT_W-1:0] PIX_Y,
  input  logic [7:0]         PIX_R,
  input  logic [7:0]         PIX_G,
  input  logic [7:0]         PIX_B,
  output logic               FRAME_START,
  VIDEO_IF.OUT               video
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_q, div_d;
  logic             dclk_q, dclk_d;
  logic             frame_q, frame_d;
  pix_tag_t         tag_q, tag_d;
  video_out_t       out_q, out_d;

  logic             stb;
  logic [COUNT_W-1:0] h_count, v_count;
  logic             h_carry, v_carry;
  logic             h_active, v_active;
  logic             h_sync, v_sync;

  assign stb = ENABLE && (div_q == DIV_LAST);

  video_sync_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_counter (
    .clk      (CLK),
    .rst      (RESET),
    .clr_i    (!ENABLE),
    .adv_i    (stb),
    .count_o  (h_count),
    .carry_o  (h_carry),
    .active_o (h_active),
    .sync_o   (h_sync)
  );

  video_sync_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_counter (
    .clk      (CLK),
    .rst      (RESET),
    .clr_i    (!ENABLE),
    .adv_i    (h_carry),
    .count_o  (v_count),
    .carry_o  (v_carry),
    .active_o (v_active),
    .sync_o   (v_sync)
  );

  // frame_q marks that the next strobe is X=0,Y=0: after reset/disable or a full-frame wrap.
  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    tag_d   = tag_q;
    out_d   = out_q;
    if (!ENABLE) begin
      div_d   = '0;
      frame_d = 1'b1;
      tag_d   = '0;
      out_d   = VIDEO_OUT_IDLE;
    end else begin
      div_d = stb ? '0 : div_q + DIV_W'(1);
      if (stb) begin
        out_d.r    = tag_q.active ? PIX_R : 8'h00;
        out_d.g    = tag_q.active ? PIX_G : 8'h00;
        out_d.b    = tag_q.active ? PIX_B : 8'h00;
        out_d.hs_n = ~tag_q.hsync;
        out_d.vs_n = ~tag_q.vsync;
        tag_d      = '{active: h_active & v_active, hsync: h_sync, vsync: v_sync};
        frame_d    = v_carry;
      end
    end
    // Registered from the next divider value so DCLK phase matches div_q exactly.
    dclk_d = ENABLE && (div_d < DIV_HALF);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q   <= '0;
      dclk_q  <= 1'b0;
      frame_q <= 1'b1;
      tag_q   <= '0;
      out_q   <= VIDEO_OUT_IDLE;
    end else begin
      div_q   <= div_d;
      dclk_q  <= dclk_d;
      frame_q <= frame_d;
      tag_q   <= tag_d;
      out_q   <= out_d;
    end
  end

  assign PIX_STB     = stb;
  assign PIX_REQ     = stb && h_active && v_active;
  assign PIX_X       = h_count;
  assign PIX_Y       = v_count;
  assign FRAME_START = stb && frame_q;

  assign video.RESOLUTION = RESOLUTION_720_480;
  assign video.R          = out_q.r;
  assign video.G          = out_q.g;
  assign video.B          = out_q.b;
  assign video.HS_n       = out_q.hs_n;
  assign video.VS_n       = out_q.vs_n;
  assign video.DCLK       = dclk_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen on a reduced raster, checked every cycle
// against an arithmetic model of clock count -> pixel index -> X/Y/regions.
`timescale 1ns/1ps
module tb_video_timing_gen;
  import VIDEO::*;

  localparam int D    = 4;
  localparam int HA   = 20;
  localparam int HF   = 3;
  localparam int HS   = 4;
  localparam int HB   = 5;
  localparam int VA   = 6;
  localparam int VF   = 2;
  localparam int VS   = 3;
  localparam int VB   = 2;
  localparam int HT   = HA + HF + HS + HB;
  localparam int VT   = VA + VF + VS + VB;
  localparam int NCYC = 9000;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       stb, req, fs;
  logic [9:0] px, py;
  logic [7:0] pr, pg, pb;

  VIDEO_IF vid ();

  video_timing_gen #(
    .CLK_DIV  (D),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .ENABLE      (en),
    .PIX_STB     (stb),
    .PIX_REQ     (req),
    .PIX_X       (px),
    .PIX_Y       (py),
    .PIX_R       (pr),
    .PIX_G       (pg),
    .PIX_B       (pb),
    .FRAME_START (fs),
    .video       (vid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n = 0;          // enabled clock edges since the last restart
  logic [23:0] col_hist [4];   // colour driven for pixel k, indexed k%4

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_active(input int q);
    return ((q % HT) < HA) && (((q / HT) % VT) < VA);
  endfunction

  function automatic bit is_hsync(input int q);
    int x;
    x = q % HT;
    return (x >= HA + HF) && (x < HA + HF + HS);
  endfunction

  function automatic bit is_vsync(input int q);
    int y;
    y = (q / HT) % VT;
    return (y >= VA + VF) && (y < VA + VF + VS);
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_stb"},   32'(stb), 32'(0));
    check({tag, "_req"},   32'(req), 32'(0));
    check({tag, "_fs"},    32'(fs), 32'(0));
    check({tag, "_x"},     32'(px), 32'(0));
    check({tag, "_y"},     32'(py), 32'(0));
    check({tag, "_rgb"},   32'({vid.R, vid.G, vid.B}), 32'(0));
    check({tag, "_hs_n"},  32'(vid.HS_n), 32'(1));
    check({tag, "_vs_n"},  32'(vid.VS_n), 32'(1));
    check({tag, "_dclk"},  32'(vid.DCLK), 32'(0));
    check({tag, "_res"},   32'(vid.RESOLUTION), 32'(RESOLUTION_720_480));
  endtask

  // Pixel p is the one whose strobe is current or next; video shows pixel p-2.
  task automatic check_cycle();
    int          p, q;
    bit          s;
    logic [23:0] exp_rgb;
    logic        exp_hs_n, exp_vs_n;
    p = n / D;
    s = ((n % D) == D - 1);
    check("pix_stb",     32'(stb), 32'(s));
    check("pix_x",       32'(px), 32'(p % HT));
    check("pix_y",       32'(py), 32'((p / HT) % VT));
    check("pix_req",     32'(req), 32'(s && is_active(p)));
    check("frame_start", 32'(fs), 32'(s && ((p % (HT * VT)) == 0)));
    check("dclk",        32'(vid.DCLK), 32'((n > 0) && ((n % D) < D / 2)));
    q = p - 2;
    if (q < 0) begin
      exp_rgb  = '0;
      exp_hs_n = 1'b1;
      exp_vs_n = 1'b1;
    end else begin
      exp_rgb  = is_active(q) ? col_hist[q % 4] : 24'h0;
      exp_hs_n = !is_hsync(q);
      exp_vs_n = !is_vsync(q);
    end
    check("rgb",  32'({vid.R, vid.G, vid.B}), 32'(exp_rgb));
    check("hs_n", 32'(vid.HS_n), 32'(exp_hs_n));
    check("vs_n", 32'(vid.VS_n), 32'(exp_vs_n));
  endtask

  initial begin
    int          rst_hold;
    int          off_hold;
    logic [31:0] rnd;
    rst = 1'b0;
    en  = 1'b1;
    pr  = '0;
    pg  = '0;
    pb  = '0;
    for (int k = 0; k < 4; k++) col_hist[k] = '0;
    #1 rst = 1'b1;
    #1 check_reset("reset_init");
    rst_hold = 2;
    off_hold = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      if (rst || !en) n = 0;
      else n++;
      @(negedge clk);
      check_cycle();

      // New colour for the pixel whose strobe edge was just taken.
      if (n > 0 && (n % D) == 0) begin
        rnd = $urandom;
        col_hist[((n / D) - 1) % 4] = rnd[23:0];
        {pr, pg, pb} = rnd[23:0];
      end

      if (rst) begin
        if (rst_hold == 0) rst = 1'b0;
        else rst_hold--;
      end else if (!en) begin
        if (off_hold == 0) en = 1'b1;
        else off_hold--;
      end else if (c == 4000 || (c > 4000 && $urandom_range(0, 999) == 0)) begin
        en       = 1'b0;
        off_hold = (c == 4000) ? 99 : $urandom_range(3, 120);
      end else if (c == 6500 || (c > 6500 && $urandom_range(0, 1999) == 0)) begin
        rst = 1'b1;
        #1 check_reset("async_reset");
        rst_hold = $urandom_range(0, 3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per pixel (even, >=2).
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 720/16/62/60, horizontal timing in pixels.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/9/6/30, vertical timing in lines.
REQ-004 Port CLK  input  1  system clock; the only clock in the block.
REQ-005 Port RESET  input  1  asynchronous, active-high reset.
REQ-006 Port ENABLE  input  1  high = timing runs; low = counters held at zero, output blanked.
REQ-007 Port PIX_STB  output  1  one-CLK pulse per pixel period.
REQ-008 Port PIX_REQ  output  1  high with PIX_STB when the current pixel is in the active area.
REQ-009 Port PIX_X  output  10  current horizontal count (0..H_total-1).
REQ-010 Port PIX_Y  output  10  current vertical count (0..V_total-1).
REQ-011 Port PIX_R/PIX_G/PIX_B  input  8 each  upstream pixel colour for the previous request.
REQ-012 Port FRAME_START  output  1  one-CLK pulse with PIX_STB at X=0,Y=0.
REQ-013 Port video  VIDEO_IF.OUT  -  downstream video bus (RESOLUTION, R, G, B, HS_n, VS_n, DCLK).

Function
REQ-014 Divider counts 0..CLK_DIV-1; PIX_STB is asserted when the divider equals CLK_DIV-1.
REQ-015 DCLK is registered, high while divider < CLK_DIV/2, low otherwise.
REQ-016 H counter advances on PIX_STB, wraps at H_total = H_ACTIVE+H_FP+H_SYNC+H_BP (858) to 0; V advances on the H wrap, wraps at V_total (525) to 0.
REQ-017 Regions: H active 0..719, FP 720..735, sync 736..797, BP 798..857; V active 0..479, FP 480..488, sync 489..494, BP 495..524.
REQ-018 PIX_X/PIX_Y/PIX_REQ describe the pixel whose strobe is currently asserted; PIX_REQ = H active AND V active.
REQ-019 Upstream holds PIX_R/G/B valid from one CLK after a PIX_REQ strobe until the next PIX_STB; the block samples them on that next PIX_STB.
REQ-020 Output pipeline latency is exactly one pixel period: R/G/B, HS_n and VS_n update on PIX_STB, reflecting the pixel of the previous strobe.
REQ-021 R/G/B = sampled colour if the delayed pixel was active, else 0.
REQ-022 HS_n is low while the delayed H is in sync; VS_n is low while the delayed V is in sync; both are registered, with no glitches.
REQ-023 RESOLUTION is driven constant RESOLUTION_720_480.
REQ-024 ENABLE falling: on the next CLK, counters, divider and pipeline clear to their reset values.
REQ-025 ENABLE rising: the first PIX_STB occurs CLK_DIV clocks later, at X=0,Y=0, with FRAME_START.
REQ-026 Simultaneous H and V wrap: both counters go to 0 on the same strobe.

Reset
REQ-027 RESET asynchronously forces: divider=0, H=V=0, PIX_STB=0, PIX_REQ=0, FRAME_START=0, R/G/B=0, HS_n=1, VS_n=1, DCLK=0.
REQ-028 RESET mid-frame discards the pipeline; after release, timing restarts at X=0,Y=0 as in REQ-025.

Structure
REQ-029 Package VIDEO holds the 720x480 timing constants (actives, porches, syncs, totals); parameter defaults reference them.
REQ-030 Sub-module video_sync_counter (one generic wrapping counter with region decode) is instantiated once for H and once for V.

Verification
REQ-031 Reset release with ENABLE=1, CLK_DIV=4 -> first FRAME_START at 4th CLK; PIX_STB every 4 CLK; DCLK 2 high / 2 low.
REQ-032 Free run -> HS_n period 3432 CLK, low 248 CLK; first HS_n fall one pixel after X=736 strobe; frame period 1,801,800 CLK.
REQ-033 Upstream returns R=X[7:0], G=Y[7:0], B=0x5A -> video R at the pixel after request (X=5,Y=3) equals 5, G=3, B=0x5A; R/G/B=0 during blanking.
REQ-034 VS_n low for exactly 6 lines (Y 489..494, delayed one pixel); both HS_n and VS_n are low together during the overlap.
REQ-035 ENABLE deasserted at X=400,Y=200, then reasserted 100 CLK later -> outputs idle (HS_n=VS_n=1, RGB=0), restart at X=0,Y=0 with FRAME_START.
REQ-036 RESET pulsed asynchronously mid-line -> all outputs take their reset values immediately, then REQ-031 behaviour repeats.
